otter_fetch_queue: RTL and testbench

Instruction fetch stage for the pipelined OTTER. Owns the fetch PC, issues one word read per cycle on the instruction port (port 1) of `OTTER_mem_byte`, and buffers returned instructions with their PCs in a small queue. Decode drains the queue through a valid/ready handshake. A redirect from execute (branch, JAL, JALR, mret) flushes the queue and discards in-flight data, so decode never sees wrong-path instructions.

---
 rtl/otter_fetch_queue_pkg.sv | 12 +
 rtl/otter_fetch_queue_if.sv | 23 ++
 rtl/otter_fetch_queue_fifo.sv | 51 +++++
 rtl/otter_fetch_queue.sv | 88 ++++++++
 tb/tb_otter_fetch_queue.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/otter_fetch_queue_pkg.sv
// Shared types for the OTTER fetch queue: the queued {instruction, PC} entry
// and the default reset vector.
package otter_pkg;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fq_entry_t;

  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Instruction-port and decode-handshake signals of the fetch queue.
// master = fetch stage, slave = memory/decode side.
interface otter_fetch_queue_if;

  logic [31:0] MEM_ADDR1;
  logic        MEM_READ1;
  logic [31:0] MEM_DOUT1;
  logic        DE_VALID;
  logic [31:0] DE_IR;
  logic [31:0] DE_PC;
  logic        DE_READY;

  modport master (
    output MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC,
    input  MEM_DOUT1, DE_READY
  );

  modport slave (
    input  MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC,
    output MEM_DOUT1, DE_READY
  );

endinterface

// File: rtl/otter_fetch_queue_fifo.sv
// Generic DEPTH x fq_entry_t FIFO with synchronous reset/clear, push, pop and
// occupancy count. Head entry is read straight from storage.
module otter_sync_fifo
  import otter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  fq_entry_t     i_din,
  output fq_entry_t     o_dout,
  output logic [CW-1:0] o_count
);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst && !i_clr) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch stage: owns the fetch PC, issues one word read per cycle and queues
// {IR, PC} for decode. Optional MEM_DOUT1->decode bypass: OTTER_FQ_BYPASS_EN.
module otter_fetch_queue
  import otter_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = otter_pkg::OTTER_RESET_VEC,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REDIRECT,
  input  logic [31:0]          REDIRECT_PC,
  otter_fetch_queue_if.master  fq
);

  logic [31:0]   r_fpc;
  logic          r_inflight;
  logic [31:0]   r_inflightPc;

  logic [CW-1:0] w_count;
  logic [31:0]   w_credit;
  logic          w_issue;
  logic [31:0]   w_addr;
  logic          w_respValid;
  logic          w_bypass;
  logic          w_deValid;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  fq_entry_t     w_respEntry;
  fq_entry_t     w_fifoHead;
  fq_entry_t     w_head;

  // Conservative credit: queued entries plus the outstanding request must fit.
  assign w_credit = {{(32-CW){1'b0}}, w_count} + {31'b0, r_inflight};
  assign w_issue  = !RESET && (REDIRECT || (w_credit < 32'(DEPTH)));
  assign w_addr   = RESET    ? RESET_VEC :
                    REDIRECT ? (REDIRECT_PC & 32'hFFFF_FFFC) : r_fpc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fpc        <= RESET_VEC;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else if (w_issue) begin
      r_fpc        <= w_addr + 32'd4;
      r_inflight   <= 1'b1;
      r_inflightPc <= w_addr;
    end else begin
      r_inflight   <= 1'b0;
    end
  end

  assign w_respValid = r_inflight && !REDIRECT;
  assign w_respEntry = '{ir: fq.MEM_DOUT1, pc: r_inflightPc};

`ifdef OTTER_FQ_BYPASS_EN
  assign w_bypass = w_respValid && (w_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head    = w_bypass ? w_respEntry : w_fifoHead;
  assign w_deValid = !RESET && ((w_count != '0) || w_bypass);
  assign w_xfer    = w_deValid && fq.DE_READY && !REDIRECT;
  assign w_pop     = w_xfer && (w_count != '0);
  // A bypassed response that decode accepts never enters the queue.
  assign w_push    = w_respValid && !(w_bypass && w_xfer);

  otter_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clr   (REDIRECT),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_respEntry),
    .o_dout  (w_fifoHead),
    .o_count (w_count)
  );

  assign fq.MEM_READ1 = w_issue;
  assign fq.MEM_ADDR1 = w_addr;
  assign fq.DE_VALID  = w_deValid;
  assign fq.DE_IR     = w_deValid ? w_head.ir : 32'h0;
  assign fq.DE_PC     = w_deValid ? w_head.pc : 32'h0;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed-vector bench for otter_fetch_queue; the memory model returns word = address.
// Expectations follow the build: OTTER_FQ_BYPASS_EN selects the bypass table.
module tb_otter_fetch_queue;
  import otter_pkg::*;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        expRead;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

`ifdef OTTER_FQ_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic        ready;
  logic [31:0] rpc;
  logic [31:0] memDout;
  int          checks   = 0;
  int          failures = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  otter_fetch_queue_if fqIf();
  assign fqIf.MEM_DOUT1 = memDout;
  assign fqIf.DE_READY  = ready;

  otter_fetch_queue #(.DEPTH(4), .RESET_VEC(32'h0000_0000)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .REDIRECT    (redir),
    .REDIRECT_PC (rpc),
    .fq          (fqIf)
  );

  // Memory answers one cycle after the request; idle cycles return junk.
  always @(posedge clk) memDout <= fqIf.MEM_READ1 ? fqIf.MEM_ADDR1 : 32'hDEAD_BEEF;

  function automatic vec_t mk(logic rs, logic rd, logic [31:0] rp, logic rdy,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.rst = rs; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.expRead = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst   = v.rst;
    redir = v.redir;
    rpc   = v.rpc;
    ready = v.ready;
    #4;
    checkOutput("MEM_READ1", idx, 32'(fqIf.MEM_READ1), 32'(v.expRead));
    checkOutput("MEM_ADDR1", idx, fqIf.MEM_ADDR1, v.expAddr);
    checkOutput("DE_VALID",  idx, 32'(fqIf.DE_VALID), 32'(v.expValid));
    checkOutput("DE_PC",     idx, fqIf.DE_PC, v.expPc);
    checkOutput("DE_IR",     idx, fqIf.DE_IR, v.expValid ? v.expPc : 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        found;
    int          lat;
    logic [31:0] pcSeen;

`ifdef OTTER_FQ_BYPASS_EN
    vecs.push_back(mk(1, 0, 0,      0, 0, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h04, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h08, 1, 32'h04));
    vecs.push_back(mk(0, 1, 32'h40, 1, 1, 32'h40, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h44, 1, 32'h40));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h48, 1, 32'h44));
    vecs.push_back(mk(0, 0, 0,      0, 1, 32'h4C, 1, 32'h48));
    vecs.push_back(mk(0, 0, 0,      0, 1, 32'h50, 1, 32'h48));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h54, 1, 32'h48));
    vecs.push_back(mk(0, 0, 0,      1, 1, 32'h58, 1, 32'h4C));
`else
    // Reset, then streaming: DE_VALID two cycles after reset drops.
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h08));
    // Decode stalled for ten cycles: issue stops once four are owed.
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h14, 1, 32'h0C));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h18, 1, 32'h0C));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h1C, 1, 32'h0C));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 32'h1C, 1, 32'h0C));
    // Release: fetch resumes the cycle after the first pop, PCs contiguous.
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h1C, 1, 32'h0C));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h1C, 1, 32'h10));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h20, 1, 32'h14));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h24, 1, 32'h18));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h28, 1, 32'h1C));
    // Build three queued + one in flight, then redirect to 0x100.
    vecs.push_back(mk(0, 0, 0,       0, 1, 32'h2C,  1, 32'h20));
    vecs.push_back(mk(0, 1, 32'h100, 0, 1, 32'h100, 1, 32'h20));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'h104, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'h108, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'h10C, 1, 32'h104));
    // Misaligned redirect target with decode ready: pop ignored.
    vecs.push_back(mk(0, 1, 32'h203, 1, 1, 32'h200, 1, 32'h108));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'h204, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'h208, 1, 32'h200));
    // Fetch PC wraps past the top of the address space.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 1, 32'h204));
    vecs.push_back(mk(0, 0, 0,             1, 1, 32'h00,        0, 32'h00));
    vecs.push_back(mk(0, 0, 0,             1, 1, 32'h04,        1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0,             1, 1, 32'h08,        1, 32'h00));
    vecs.push_back(mk(0, 0, 0,             1, 1, 32'h0C,        1, 32'h04));
    // Reset mid-stream discards everything and restarts at the reset vector.
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04));
`endif

    rst = 1'b1; redir = 1'b0; rpc = '0; ready = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] applying %0d vectors", vecs.size());
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset beats a simultaneous redirect; first fetch afterwards is the reset vector.
    rst = 1'b1; redir = 1'b1; rpc = 32'h300; ready = 1'b1;
    #4;
    checkOutput("rstPrioRead", 0, 32'(fqIf.MEM_READ1), 32'h0);
    checkOutput("rstPrioAddr", 0, fqIf.MEM_ADDR1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; redir = 1'b0;
    found = 1'b0; lat = 0; pcSeen = '0;
    for (int n = 0; n < 6 && !found; n++) begin
      #4;
      if (fqIf.DE_VALID) begin
        found  = 1'b1;
        lat    = n;
        pcSeen = fqIf.DE_PC;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("firstValidSeen", 0, 32'(found), 32'h1);
    checkOutput("firstValidLat",  0, 32'(lat), 32'(FIRST_LAT));
    checkOutput("firstValidPc",   0, pcSeen, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
